// File: rtl/chip8_alu_sequencer.sv
// rtl/chip8_alu_sequencer.sv - CHIP-8 8XYN ALU opcode sequencer (read Vx/Vy, drive ALU, write Vx then VF)
// Optional macro CHIP8_SHIFT_VY_EN: 8XY6/8XYE shift Vy instead of Vx.
module chip8_alu_sequencer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [15:0] opcode,
    output logic [3:0]  rf_raddr,
    input  logic [7:0]  rf_rdata,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [7:0]  rf_wdata,
    output logic [3:0]  alu_sel,
    output logic [15:0] alu_in1,
    output logic [15:0] alu_in2,
    input  logic [15:0] alu_out,
    input  logic        alu_carry,
    output logic        done,
    output logic        illegal
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD_X = 3'd1;
    localparam logic [2:0] S_RD_Y = 3'd2;
    localparam logic [2:0] S_EXEC = 3'd3;
    localparam logic [2:0] S_WB_X = 3'd4;
    localparam logic [2:0] S_WB_F = 3'd5;
    localparam logic [2:0] S_ERR  = 3'd6;

    logic [2:0] state_q, state_d;
    logic [3:0] x_q, x_d, y_q, y_d, n_q, n_d;
    logic [7:0] vx_q, vx_d, res_q, res_d;
    logic       flag_q, flag_d;
    logic [7:0] vy, src;
    logic       legal;
    logic       unused_alu_hi;

    // Vy is still on the read port during EXEC, so it feeds the ALU directly.
    assign vy = rf_rdata;
`ifdef CHIP8_SHIFT_VY_EN
    assign src = vy;
`else
    assign src = vx_q;
`endif
    assign legal = (opcode[15:12] == 4'h8) &&
                   ((opcode[3:0] <= 4'h7) || (opcode[3:0] == 4'hE));
    assign unused_alu_hi = ^alu_out[15:8];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            x_q     <= 4'h0;
            y_q     <= 4'h0;
            n_q     <= 4'h0;
            vx_q    <= 8'h00;
            res_q   <= 8'h00;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            n_q     <= n_d;
            vx_q    <= vx_d;
            res_q   <= res_d;
            flag_q  <= flag_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        n_d      = n_q;
        vx_d     = vx_q;
        res_d    = res_q;
        flag_d   = flag_q;
        op_ready = 1'b0;
        rf_raddr = 4'h0;
        rf_we    = 1'b0;
        rf_waddr = 4'h0;
        rf_wdata = 8'h00;
        alu_sel  = 4'h0;
        alu_in1  = 16'h0000;
        alu_in2  = 16'h0000;
        done     = 1'b0;
        illegal  = 1'b0;
        case (state_q)
            S_IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    x_d     = opcode[11:8];
                    y_d     = opcode[7:4];
                    n_d     = opcode[3:0];
                    state_d = legal ? S_RD_X : S_ERR;
                end
            end
            S_RD_X: begin
                rf_raddr = x_q;
                state_d  = S_RD_Y;
            end
            S_RD_Y: begin
                rf_raddr = y_q;
                vx_d     = rf_rdata;
                state_d  = S_EXEC;
            end
            S_EXEC: begin
                alu_in1 = {8'h00, vx_q};
                alu_in2 = {8'h00, vy};
                flag_d  = 1'b0;
                case (n_q)
                    4'h0: begin alu_sel = 4'd1; alu_in1 = 16'h0000; end
                    4'h1: alu_sel = 4'd1;
                    4'h2: alu_sel = 4'd2;
                    4'h3: alu_sel = 4'd3;
                    4'h4: begin alu_sel = 4'd4; flag_d = alu_carry; end
                    4'h5: begin alu_sel = 4'd5; flag_d = (vx_q >= vy); end
                    4'h7: begin
                        alu_sel = 4'd5;
                        alu_in1 = {8'h00, vy};
                        alu_in2 = {8'h00, vx_q};
                        flag_d  = (vy >= vx_q);
                    end
                    4'h6: begin
                        alu_sel = 4'd7;
                        alu_in1 = {8'h00, src};
                        alu_in2 = 16'h0001;
                        flag_d  = src[0];
                    end
                    default: begin
                        alu_sel = 4'd6;
                        alu_in1 = {8'h00, src};
                        alu_in2 = 16'h0001;
                        flag_d  = src[7];
                    end
                endcase
                res_d   = alu_out[7:0];
                state_d = S_WB_X;
            end
            S_WB_X: begin
                rf_we    = 1'b1;
                rf_waddr = x_q;
                rf_wdata = res_q;
                if (n_q <= 4'h3) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WB_F;
                end
            end
            S_WB_F: begin
                rf_we    = 1'b1;
                rf_waddr = 4'hF;
                rf_wdata = {7'b0, flag_q};
                done     = 1'b1;
                state_d  = S_IDLE;
            end
            S_ERR: begin
                illegal = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_chip8_alu_sequencer.sv
// tb/tb_chip8_alu_sequencer.sv - self-checking bench for chip8_alu_sequencer with register file and ALU models
module tb_chip8_alu_sequencer;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [15:0] opcode = 16'h0000;
    logic [3:0]  rf_raddr;
    logic [7:0]  rf_rdata = 8'h00;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [7:0]  rf_wdata;
    logic [3:0]  alu_sel;
    logic [15:0] alu_in1, alu_in2;
    logic [15:0] alu_out;
    logic        alu_carry;
    logic        done, illegal;

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0] V [16];
    logic [7:0] pl_vals [16];
    logic       pl_load = 1'b0;
    int         we_cnt = 0;

    logic [15:0] wr_q [$];
    int done_at, ill_at, ready_after, busy_ready_bad;

    chip8_alu_sequencer dut (
        .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .op_ready(op_ready),
        .opcode(opcode), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .alu_sel(alu_sel),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_out(alu_out),
        .alu_carry(alu_carry), .done(done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_load) V <= pl_vals;
        else if (rf_we) V[rf_waddr] <= rf_wdata;
        rf_rdata <= V[rf_raddr];
        if (rf_we) we_cnt <= we_cnt + 1;
    end

    always_comb begin
        alu_out   = 16'h0000;
        alu_carry = 1'b0;
        case (alu_sel)
            4'd1: alu_out = alu_in1 | alu_in2;
            4'd2: alu_out = alu_in1 & alu_in2;
            4'd3: alu_out = alu_in1 ^ alu_in2;
            4'd4: begin alu_out = alu_in1 + alu_in2; alu_carry = (alu_out > 16'd255); end
            4'd5: alu_out = alu_in1 - alu_in2;
            4'd6: alu_out = alu_in1 << 1;
            4'd7: alu_out = alu_in1 >> 1;
            default: alu_out = 16'h0000;
        endcase
    end

    // Architectural result of 8XYN: {flag, value written to Vx}
    function automatic logic [8:0] ref_op(input int n, input int vx, input int vy);
        int s, r, f;
`ifdef CHIP8_SHIFT_VY_EN
        s = vy;
`else
        s = vx;
`endif
        f = 0;
        case (n)
            0: r = vy;
            1: r = vx | vy;
            2: r = vx & vy;
            3: r = vx ^ vy;
            4: begin r = vx + vy; f = (r > 255) ? 1 : 0; end
            5: begin r = vx - vy; f = (vx >= vy) ? 1 : 0; end
            7: begin r = vy - vx; f = (vy >= vx) ? 1 : 0; end
            6: begin r = s / 2; f = s % 2; end
            default: begin r = s * 2; f = s / 128; end
        endcase
        r = r & 255;
        return {f[0], r[7:0]};
    endfunction

    task automatic load_regs();
        @(negedge clk);
        pl_load = 1'b1;
        @(negedge clk);
        pl_load = 1'b0;
    endtask

    task automatic run_op(input logic [15:0] op);
        wr_q.delete();
        done_at = 0; ill_at = 0; ready_after = 0; busy_ready_bad = 0;
        @(negedge clk);
        op_valid = 1'b1;
        opcode   = op;
        @(posedge clk);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (done_at != 0 || ill_at != 0) begin
                ready_after = op_ready;
                break;
            end
            if (op_ready) busy_ready_bad = 1;
            if (rf_we) wr_q.push_back({c[3:0], rf_waddr, rf_wdata});
            if (done) done_at = c;
            if (illegal) ill_at = c;
            if (done || illegal) op_valid = 1'b0;
            opcode = 16'h0000;
        end
        op_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({rf_we, done, illegal, alu_sel, rf_raddr, rf_waddr, rf_wdata, alu_in1, alu_in2} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got we=%0b done=%0b ill=%0b sel=%0d raddr=%0d waddr=%0d wdata=%h in1=%h in2=%h, required all zero",
                     rf_we, done, illegal, alu_sel, rf_raddr, rf_waddr, rf_wdata, alu_in1, alu_in2);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (op_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b required 1", op_ready);
        end
    endtask

    task automatic test_logic();
        pl_vals = '{default: 8'h00};
        pl_vals[1] = 8'h0F; pl_vals[2] = 8'hF0; pl_vals[15] = 8'h5A;
        load_regs();
        run_op(16'h8121);
        n_checks++;
        if (done_at !== 4 || wr_q.size() !== 1) begin
            n_fail++;
            $display("FAIL or_timing: done at %0d with %0d writes, required done at 4 with 1 write", done_at, wr_q.size());
        end
        n_checks++;
        if (wr_q.size() < 1 || wr_q[0] !== 16'h41FF || V[1] !== 8'hFF || V[15] !== 8'h5A) begin
            n_fail++;
            $display("FAIL or_result: V1=%h VF=%h, required V1=ff VF=5a with write 41ff at T4", V[1], V[15]);
        end
    endtask

    task automatic test_add();
        pl_vals = '{default: 8'h00};
        pl_vals[3] = 8'hC8; pl_vals[4] = 8'h64;
        load_regs();
        run_op(16'h8344);
        n_checks++;
        if (done_at !== 5 || wr_q.size() !== 2 || wr_q[0] !== 16'h432C || wr_q[1] !== 16'h5F01) begin
            n_fail++;
            $display("FAIL add_carry: done at %0d, V3=%h VF=%h, required done 5, V3=2c then VF=01", done_at, V[3], V[15]);
        end
        pl_vals[3] = 8'h10; pl_vals[15] = 8'h77;
        load_regs();
        run_op(16'h8344);
        n_checks++;
        if (done_at !== 5 || V[3] !== 8'h74 || V[15] !== 8'h00) begin
            n_fail++;
            $display("FAIL add_nocarry: done at %0d, V3=%h VF=%h, required done 5, V3=74 VF=00", done_at, V[3], V[15]);
        end
    endtask

    task automatic test_sub();
        pl_vals = '{default: 8'h00};
        pl_vals[5] = 8'h05; pl_vals[6] = 8'h07;
        load_regs();
        run_op(16'h8565);
        n_checks++;
        if (done_at !== 5 || V[5] !== 8'hFE || V[15] !== 8'h00) begin
            n_fail++;
            $display("FAIL sub_borrow: done at %0d, V5=%h VF=%h, required done 5, V5=fe VF=00", done_at, V[5], V[15]);
        end
        load_regs();
        run_op(16'h8567);
        n_checks++;
        if (done_at !== 5 || V[5] !== 8'h02 || V[15] !== 8'h01) begin
            n_fail++;
            $display("FAIL subn: done at %0d, V5=%h VF=%h, required done 5, V5=02 VF=01", done_at, V[5], V[15]);
        end
    endtask

    task automatic test_shift_vf();
        logic [8:0] e;
        pl_vals = '{default: 8'h00};
        pl_vals[15] = 8'h81;
        pl_vals[0]  = 8'h40;
        load_regs();
        run_op(16'h8F0E);
        e = ref_op(14, 'h81, 'h40);
        n_checks++;
        if (wr_q.size() !== 2 || wr_q[0] !== {4'h4, 4'hF, e[7:0]} || wr_q[1] !== {4'h5, 4'hF, 7'b0, e[8]}) begin
            n_fail++;
            $display("FAIL shl_vf_writes: %0d writes, first %h, required 4f%h then 5f0%0d", wr_q.size(),
                     (wr_q.size() > 0) ? wr_q[0] : 16'hxxxx, e[7:0], e[8]);
        end
        n_checks++;
        if (V[15] !== {7'b0, e[8]} || done_at !== 5) begin
            n_fail++;
            $display("FAIL shl_vf_final: VF=%h done at %0d, required VF=%h done at 5", V[15], done_at, {7'b0, e[8]});
        end
    endtask

    task automatic test_illegal();
        logic [15:0] ops [3];
        ops[0] = 16'h812F; ops[1] = 16'h7123; ops[2] = 16'h8AB8;
        for (int i = 0; i < 3; i++) begin
            int w0;
            w0 = we_cnt;
            run_op(ops[i]);
            n_checks++;
            if (ill_at !== 1 || done_at !== 0 || we_cnt !== w0 || ready_after !== 1 || busy_ready_bad !== 0) begin
                n_fail++;
                $display("FAIL illegal_%h: illegal at %0d done at %0d writes %0d ready_after %0d, required illegal at 1, no done, no writes, ready 1",
                         ops[i], ill_at, done_at, we_cnt - w0, ready_after);
            end
        end
    endtask

    task automatic test_reset_mid();
        int w0;
        pl_vals = '{default: 8'h00};
        pl_vals[1] = 8'h11; pl_vals[2] = 8'h22;
        load_regs();
        w0 = we_cnt;
        @(negedge clk);
        op_valid = 1'b1;
        opcode   = 16'h8124;
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (alu_sel !== 4'd4) begin
            n_fail++;
            $display("FAIL exec_sel: alu_sel %0d in T3, required 4", alu_sel);
        end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (rf_we !== 1'b0 || done !== 1'b0 || alu_sel !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_mid_async: we=%b done=%b sel=%0d, required 0 0 0", rf_we, done, alu_sel);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        n_checks++;
        if (V[1] !== 8'h11 || we_cnt !== w0 || op_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_after: V1=%h writes=%0d ready=%b, required V1=11 writes=0 ready=1", V[1], we_cnt - w0, op_ready);
        end
    endtask

    task automatic test_back_to_back();
        int nlist [9] = '{0, 1, 2, 3, 4, 5, 6, 7, 14};
        int bad = 0;
        for (int it = 0; it < 60; it++) begin
            logic [7:0] ex [16];
            logic [8:0] e;
            int x, y, n, edone;
            for (int r = 0; r < 16; r++) pl_vals[r] = 8'($urandom);
            if (it % 8 != 0) load_regs();
            else pl_vals = V;
            x = $urandom_range(0, 15);
            y = $urandom_range(0, 15);
            n = nlist[$urandom_range(0, 8)];
            ex = pl_vals;
            e  = ref_op(n, ex[x], ex[y]);
            ex[x] = e[7:0];
            if (n > 3) ex[15] = {7'b0, e[8]};
            edone = (n > 3) ? 5 : 4;
            run_op({4'h8, x[3:0], y[3:0], n[3:0]});
            n_checks++;
            if (done_at !== edone || ill_at !== 0 || ready_after !== 1 || busy_ready_bad !== 0 || wr_q.size() !== edone - 3) begin
                n_fail++; bad++;
                $display("FAIL rand_timing op %h: done at %0d illegal at %0d ready_after %0d writes %0d, required done at %0d, %0d writes",
                         {4'h8, x[3:0], y[3:0], n[3:0]}, done_at, ill_at, ready_after, wr_q.size(), edone, edone - 3);
            end
            n_checks++;
            if (V !== ex) begin
                n_fail++; bad++;
                $display("FAIL rand_result op %h: Vx=%h VF=%h, required Vx=%h VF=%h",
                         {4'h8, x[3:0], y[3:0], n[3:0]}, V[x], V[15], ex[x], ex[15]);
            end
            if (bad > 6) break;
        end
    endtask

    initial begin
        pl_vals = '{default: 8'h00};
        test_reset();
        load_regs();
        test_logic();
        test_add();
        test_sub();
        test_shift_vf();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/chip8_alu_sequencer.md
# chip8_alu_sequencer

Executes CHIP-8 arithmetic/logic opcodes (8XYN group) on behalf of the CPU decoder. It accepts one opcode over a valid/ready handshake and reads Vx and Vy from the V register file. It drives the combinational ALU, then writes the result back to Vx and, where the opcode defines it, the flag back to VF. It sits between the CPU's fetch/decode stage, the V register file and the ALU.

## Interface
- No parameters; data path fixed at 8-bit registers, 16-bit ALU ports.
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- op_valid  in  1  opcode offered
- op_ready  out  1  high only in IDLE; transfer when op_valid && op_ready
- opcode  in  16  full CHIP-8 instruction, sampled on transfer
- rf_raddr  out  4  V register read address
- rf_rdata  in  8  read data, valid one cycle after rf_raddr
- rf_we  out  1  register write strobe
- rf_waddr  out  4  write address
- rf_wdata  out  8  write data
- alu_sel  out  4  ALU op: 1 OR, 2 AND, 3 XOR, 4 ADD, 5 SUB, 6 SHL, 7 SHR, 0 idle
- alu_in1, alu_in2  out  16  ALU operands, 8-bit values zero-extended
- alu_out  in  16  ALU result, combinational; low 8 bits used
- alu_carry  in  1  ALU carry (meaningful for ADD only)
- done  out  1  one-cycle pulse on final write of a legal opcode
- illegal  out  1  one-cycle pulse for a rejected opcode

## Operation
- States: IDLE, RD_X, RD_Y, EXEC, WB_X, WB_F, ERR.
- IDLE: op_ready=1. On transfer, latch X=opcode[11:8], Y=opcode[7:4], N=opcode[3:0]. Go to RD_X if opcode[15:12]=8 and N is in {0,1,2,3,4,5,6,7,E}; otherwise go to ERR.
- RD_X: rf_raddr=X. RD_Y: capture vx from rf_rdata; rf_raddr=Y. EXEC: capture vy; drive ALU; register res=alu_out[7:0] and flag.
- ALU mapping:
  - N=0: sel 1, in1=0, in2=vy (LD).
  - N=1/2/3: sel 1/2/3, in1=vx, in2=vy.
  - N=4: sel 4; flag=alu_carry.
  - N=5: sel 5, in1=vx, in2=vy; flag=(vx>=vy).
  - N=7: sel 5, in1=vy, in2=vx; flag=(vy>=vx).
  - N=6: sel 7, in1=src, in2=1; flag=src[0].
  - N=E: sel 6, in1=src, in2=1; flag=src[7].
  - src is set by configuration.
- Arithmetic wraps modulo 256 via truncation to alu_out[7:0].
- WB_X: rf_we=1, rf_waddr=X, rf_wdata=res.
  - N in {0,1,2,3}: VF untouched; done=1 in WB_X; go to IDLE.
  - Else go to WB_F.
- WB_F: rf_we=1, rf_waddr=F, rf_wdata={7'b0,flag}; done=1; go to IDLE. When X=F, VF therefore ends as the flag.
- ERR: illegal=1; no register access; go to IDLE.
- Outside EXEC: alu_sel=0, alu_in1=alu_in2=0. Outside WB states: rf_we=0.

## Timing
- Reset values: state IDLE, op_ready=1 once reset_n deasserts (0 while asserted is acceptable), rf_we=0, rf_raddr=0, rf_waddr=0, rf_wdata=0, alu_sel=0, alu_in1=alu_in2=0, done=0, illegal=0.
- Transfer at edge T0:
  - RD_X in cycle T1, RD_Y in T2, EXEC in T3, WB_X in T4, WB_F in T5.
  - done at T4 (N=0..3) or T5.
  - illegal at T1.
- op_ready is low from T1 until return to IDLE. The next transfer is possible in the cycle after done or illegal.
- op_valid and opcode are ignored when op_ready=0.
- reset_n asserted mid-operation: immediate return to IDLE. No pending write completes; rf_we, done and illegal drop asynchronously.

## Configuration
- CHIP8_SHIFT_VY_EN defined: shift source src=vy (COSMAC VIP semantics); result still written to Vx.
- Undefined: src=vx; vy is read but unused for N=6/E.

## Test plan
- V1=0x0F, V2=0xF0, opcode 0x8121 → V1=0xFF at T4, done at T4, VF unchanged.
- V3=0xC8, V4=0x64, opcode 0x8344 → V3=0x2C, then VF=1, done at T5; with V3=0x10 → V3=0x74, VF=0.
- V5=0x05, V6=0x07, opcode 0x8565 → V5=0xFE, VF=0; opcode 0x8567 with the same values → V5=0x02, VF=1.
- VF=0x81, opcode 0x8F0E without the macro → writes VF=0x02 then VF=1; final VF=0x01.
- Opcode 0x812F, then 0x7123 → illegal pulse one cycle after each transfer, rf_we never asserted, op_ready high again the next cycle.
- reset_n low during EXEC of 0x8124 → V1 not written, no done, op_ready=1 after release.
